// File: rtl/cmp_serial_if.sv
// Start/operand request and compare-result bundle for the bit-serial comparator.
// The master drives start/a/b; the slave returns busy/done, the flags and nbits.
interface cmp_serial_if #(
  parameter int WIDTH = 8
);
  localparam int NW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [NW-1:0]    nbits;

  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt, nbits
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt, nbits
  );
endinterface

// File: rtl/cmp_serial.sv
// Bit-serial MSB-first magnitude comparator with early exit; 1..WIDTH cycles per compare.
// start is taken only in IDLE and is neither queued nor stalled while busy.
module cmp_serial #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  cmp_serial_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int NW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NW-1:0]    cnt_q, cnt_d, nbits_q, nbits_d;
  logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, done_q, done_d;
  logic             a_bit, b_bit, sign_pos;
  logic [NW-1:0]    cnt_inc;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    nbits_d  = nbits_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    done_d   = 1'b0;
    a_bit    = a_q[idx_q];
    b_bit    = b_q[idx_q];
    sign_pos = SIGNED && (idx_q == MSB_IDX);
    cnt_inc  = cnt_q + NW'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = MSB_IDX;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (a_bit != b_bit) begin
          // A set sign bit means the more negative operand, so the sense flips.
          gt_d    = a_bit ^ sign_pos;
          lt_d    = ~(a_bit ^ sign_pos);
          eq_d    = 1'b0;
          nbits_d = cnt_inc;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          nbits_d = cnt_inc;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      nbits_q <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      nbits_q <= nbits_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.gt    = gt_q;
  assign bus.eq    = eq_q;
  assign bus.lt    = lt_q;
  assign bus.nbits = nbits_q;
endmodule

// File: tb/tb_cmp_serial.sv
// Randomised and directed bench for cmp_serial: WIDTH=8 and WIDTH=3, each in unsigned and signed form.
module tb_cmp_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       st8 = 1'b0, st3 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [2:0] a3 = '0, b3 = '0;

  cmp_serial_if #(.WIDTH(8)) i8u ();
  cmp_serial_if #(.WIDTH(8)) i8s ();
  cmp_serial_if #(.WIDTH(3)) i3u ();
  cmp_serial_if #(.WIDTH(3)) i3s ();

  assign i8u.start = st8;  assign i8u.a = a8;  assign i8u.b = b8;
  assign i8s.start = st8;  assign i8s.a = a8;  assign i8s.b = b8;
  assign i3u.start = st3;  assign i3u.a = a3;  assign i3u.b = b3;
  assign i3s.start = st3;  assign i3s.a = a3;  assign i3s.b = b3;

  cmp_serial #(.WIDTH(8), .SIGNED(1'b0)) u8u (.clk(clk), .rst(rst), .bus(i8u.slave));
  cmp_serial #(.WIDTH(8), .SIGNED(1'b1)) u8s (.clk(clk), .rst(rst), .bus(i8s.slave));
  cmp_serial #(.WIDTH(3), .SIGNED(1'b0)) u3u (.clk(clk), .rst(rst), .bus(i3u.slave));
  cmp_serial #(.WIDTH(3), .SIGNED(1'b1)) u3s (.clk(clk), .rst(rst), .bus(i3s.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: bits examined = WIDTH minus position of the highest differing bit.
  function automatic int exp_n(input int w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x;
    x = a ^ b;
    for (int i = w - 1; i >= 0; i--)
      if (x[i]) return w - i;
    return w;
  endfunction

  // Reference: {gt,eq,lt} from integer values of the operands.
  function automatic logic [2:0] exp_flags(input int w, input bit sgn,
                                           input logic [63:0] a, input logic [63:0] b);
    longint av, bv;
    av = longint'(a);
    bv = longint'(b);
    if (sgn && a[w-1]) av = av - (longint'(1) << w);
    if (sgn && b[w-1]) bv = bv - (longint'(1) << w);
    if (av > bv) return 3'b100;
    if (av == bv) return 3'b010;
    return 3'b001;
  endfunction

  // Issues one compare on the 8-bit pair from a negedge; returns at the done negedge.
  task automatic cmp8(input logic [7:0] a, input logic [7:0] b, input string tag);
    int lat;
    a8 = a; b8 = b; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    a8 = ~a; b8 = a;
    chk({tag, "_busy"}, i8u.busy, 1);
    lat = 0;
    while (!i8u.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_n(8, a, b));
    chk({tag, "_s_done"}, i8s.done, 1);
    chk({tag, "_idle"}, i8u.busy, 0);
    chk({tag, "_u_flags"}, {i8u.gt, i8u.eq, i8u.lt}, exp_flags(8, 1'b0, a, b));
    chk({tag, "_s_flags"}, {i8s.gt, i8s.eq, i8s.lt}, exp_flags(8, 1'b1, a, b));
    chk({tag, "_u_nbits"}, i8u.nbits, exp_n(8, a, b));
    chk({tag, "_s_nbits"}, i8s.nbits, exp_n(8, a, b));
  endtask

  task automatic cmp3(input logic [2:0] a, input logic [2:0] b);
    int lat;
    a3 = a; b3 = b; st3 = 1'b1;
    @(negedge clk);
    st3 = 1'b0;
    lat = 0;
    while (!i3u.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("x3_lat", lat, exp_n(3, a, b));
    chk("x3_s_done", i3s.done, 1);
    chk("x3_u_flags", {i3u.gt, i3u.eq, i3u.lt}, exp_flags(3, 1'b0, a, b));
    chk("x3_s_flags", {i3s.gt, i3s.eq, i3s.lt}, exp_flags(3, 1'b1, a, b));
    chk("x3_u_lat_nbits", i3u.nbits, lat);
    chk("x3_s_nbits", i3s.nbits, exp_n(3, a, b));
    chk("x3_u_onehot", 32'(i3u.gt) + 32'(i3u.eq) + 32'(i3u.lt), 1);
    chk("x3_s_onehot", 32'(i3s.gt) + 32'(i3s.eq) + 32'(i3s.lt), 1);
  endtask

  initial begin
    int dcount;
    logic [2:0] hflags;
    logic [3:0] hnbits;
    logic [7:0] ra, rb;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", i8u.busy, 0);
    chk("rst_done", i8u.done, 0);
    chk("rst_flags", {i8u.gt, i8u.eq, i8u.lt}, 0);
    chk("rst_nbits", i8u.nbits, 0);
    chk("rst_s_flags", {i8s.gt, i8s.eq, i8s.lt, i8s.nbits}, 0);

    // Directed cases, issued back to back.
    cmp8(8'hA5, 8'h25, "early");
    cmp8(8'h3C, 8'h3D, "late");
    cmp8(8'h80, 8'h01, "sign");
    cmp8(8'hFE, 8'hFF, "neg");
    cmp8(8'h7F, 8'h7F, "equal");
    repeat (5) begin
      @(negedge clk);
      chk("hold_done", i8u.done, 0);
      chk("hold_flags", {i8u.gt, i8u.eq, i8u.lt}, 3'b010);
      chk("hold_nbits", i8u.nbits, 8);
    end

    for (int k = 0; k < 24; k++) begin
      ra = 8'($urandom);
      rb = (k % 3 == 0) ? (ra ^ (8'd1 << $urandom_range(7, 0))) : 8'($urandom);
      if (k % 7 == 0) rb = ra;
      cmp8(ra, rb, "rand");
    end

    // Second start while busy is dropped; operand changes after accept are ignored.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h11; st8 = 1'b1;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00;
    @(negedge clk);
    st8 = 1'b0;
    dcount = 0;
    hflags = '0;
    hnbits = '0;
    for (int c = 0; c < 16; c++) begin
      if (i8u.done) begin
        dcount++;
        hflags = {i8u.gt, i8u.eq, i8u.lt};
        hnbits = i8u.nbits;
      end
      @(negedge clk);
    end
    chk("hs_dones", dcount, 1);
    chk("hs_flags", hflags, 3'b001);
    chk("hs_nbits", hnbits, 8);

    // Reset in the middle of a long compare.
    a8 = 8'h00; b8 = 8'h01; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", i8u.busy, 0);
    chk("mid_rst_done", i8u.done, 0);
    chk("mid_rst_flags", {i8u.gt, i8u.eq, i8u.lt}, 0);
    chk("mid_rst_nbits", i8u.nbits, 0);
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (i8u.done || i8s.done) dcount++;
    end
    chk("mid_rst_no_done", dcount, 0);

    // Exhaustive 3-bit sweep, back to back, both signed and unsigned.
    for (int ea = 0; ea < 8; ea++)
      for (int eb = 0; eb < 8; eb++)
        cmp3(3'(ea), 3'(eb));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
